// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 op codes, sequencer states and decode constants.
package riscv_m_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input m_funct3_t f3);
    return (f3 == M_MULH) || (f3 == M_MULHSU) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

  function automatic logic b_is_signed(input m_funct3_t f3);
    return (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the unsigned shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_sequencer_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  // multiply: {hi,multiplier} shifts right with carry; divide: {rem,quot} shifts left
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
    diff_s   = rem_sh_s - {1'b0, operand};
    if (is_div) begin
      // no borrow out of the WIDTH+1 bit subtract means rem >= divisor
      if (!diff_s[WIDTH]) begin
        acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: stalls EX for WIDTH steps and pulses result_valid once.
module muldiv_sequencer
  import riscv_m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO2  = {(2*WIDTH){1'b0}};

  muldiv_state_t      state_r, state_s;
  m_funct3_t          f3_r, f3_s, f3_in_s;
  logic               sa_r, sa_s, sb_r, sb_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [2*WIDTH-1:0] acc_r, acc_s, step_next_s, prod_s;
  logic [WIDTH-1:0]   b_r, b_s, result_r, result_s;
  logic               sign_a_in_s, sign_b_in_s, div_zero_s, ovf_s, special_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, special_val_s, quot_s, rem_s, fix_val_s;

  muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (f3_r[2]),
    .acc      (acc_r),
    .operand  (b_r),
    .acc_next (step_next_s)
  );

  // decode of the incoming op: magnitudes and the one-cycle RISC-V special cases
  always_comb begin
    f3_in_s     = m_funct3_t'(funct3);
    sign_a_in_s = op_a[WIDTH-1] & a_is_signed(f3_in_s);
    sign_b_in_s = op_b[WIDTH-1] & b_is_signed(f3_in_s);
    mag_a_s     = sign_a_in_s ? (ZERO - op_a) : op_a;
    mag_b_s     = sign_b_in_s ? (ZERO - op_b) : op_b;
    div_zero_s  = funct3[2] & (op_b == ZERO);
    ovf_s       = ((f3_in_s == M_DIV) || (f3_in_s == M_REM)) && (op_a == MIN_NEG) && (op_b == ONES);
    special_s   = div_zero_s | ovf_s;
    case (f3_in_s)
      M_DIV, M_DIVU: special_val_s = div_zero_s ? ONES : op_a;
      M_REM, M_REMU: special_val_s = div_zero_s ? op_a : ZERO;
      default:       special_val_s = ZERO;
    endcase
  end

  // sign fix-up and result selection; unsigned ops latch both signs as zero
  always_comb begin
    prod_s = (sa_r ^ sb_r) ? (ZERO2 - acc_r) : acc_r;
    quot_s = (sa_r ^ sb_r) ? (ZERO - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s  = sa_r ? (ZERO - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    case (f3_r)
      M_MUL:                     fix_val_s = prod_s[WIDTH-1:0];
      M_MULH, M_MULHSU, M_MULHU: fix_val_s = prod_s[2*WIDTH-1:WIDTH];
      M_DIV, M_DIVU:             fix_val_s = quot_s;
      M_REM, M_REMU:             fix_val_s = rem_s;
      default:                   fix_val_s = ZERO;
    endcase
  end

  // next-state and datapath update; flush overrides everything and leaves result untouched
  always_comb begin
    state_s  = state_r;
    f3_s     = f3_r;
    sa_s     = sa_r;
    sb_s     = sb_r;
    cnt_s    = cnt_r;
    acc_s    = acc_r;
    b_s      = b_r;
    result_s = result_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            f3_s  = f3_in_s;
            sa_s  = sign_a_in_s;
            sb_s  = sign_b_in_s;
            acc_s = {ZERO, mag_a_s};
            b_s   = mag_b_s;
            cnt_s = CNT_LAST;
            if (special_s) begin
              result_s = special_val_s;
              state_s  = DONE;
            end else begin
              state_s  = RUN;
            end
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          acc_s = step_next_s;
          if (cnt_r == CNT_ZERO) begin
            state_s = FIX;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        FIX: begin
          result_s = fix_val_s;
          state_s  = DONE;
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      f3_r     <= M_MUL;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      cnt_r    <= CNT_ZERO;
      acc_r    <= ZERO2;
      b_r      <= ZERO;
      result_r <= ZERO;
    end else begin
      state_r  <= state_s;
      f3_r     <= f3_s;
      sa_r     <= sa_s;
      sb_r     <= sb_s;
      cnt_r    <= cnt_s;
      acc_r    <= acc_s;
      b_r      <= b_s;
      result_r <= result_s;
    end
  end

  // stall is combinational so EX freezes in the very cycle the op is accepted
  assign stall        = ((state_r == IDLE) & start & ~flush & ~special_s) | (state_r == RUN) | (state_r == FIX);
  assign result_valid = (state_r == DONE);
  assign result       = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised scoreboard bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        flush = 1'b0;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;
  logic [31:0] mon_exp;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    logic            ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 32'h0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 32'h0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 32'h0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = $urandom;
      1: v = 32'h0;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'($urandom_range(0, 20));
      default: v = 32'h0 - 32'($urandom_range(1, 20));
    endcase
    return v;
  endfunction

  // scoreboard monitor: every result_valid pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: result=%h with no op outstanding", result);
      end else begin
        mon_exp = exp_q.pop_front();
        if (result !== mon_exp) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, mon_exp);
        end
      end
    end
  end

  // issue one op, hold start until the result pulse, check stall profile and latency
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sp;
    int   lat;
    int   stall_cnt;
    logic got;
    sp = is_special(f3, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    last_exp = ref_op(f3, a, b);
    exp_q.push_back(last_exp);
    #1 chk("stall_in_start_cycle", {31'h0, stall}, {31'h0, ~sp});
    lat = 0; stall_cnt = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (result_valid) got = 1'b1;
      else if (stall) stall_cnt++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), sp ? 32'd1 : 32'd34);
    chk("stall_cycles", 32'(stall_cnt), sp ? 32'd0 : 32'd33);
    @(negedge clk);
    chk("result_hold", result, last_exp);
    chk("valid_one_cycle", {31'h0, result_valid}, 32'h0);
  endtask

  logic [2:0]  d_f3[14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd0, 3'd2, 3'd6};
  logic [31:0] d_a[14]  = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h12345678, 32'h80000000, 32'h80000000};
  logic [31:0] d_b[14]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'h7FFFFFFF, 32'hFFFFFFFF};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_valid", {31'h0, result_valid}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) do_op(d_f3[i], d_a[i], d_b[i]);

    // flush in the middle of RUN: no pulse, result kept, stall gone next cycle
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'h11; op_b = 32'h22;
    repeat (10) @(negedge clk);
    chk("stall_before_flush", {31'h0, stall}, 32'h1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("stall_after_flush", {31'h0, stall}, 32'h0);
    chk("result_after_flush", result, last_exp);
    repeat (40) @(negedge clk);
    chk("result_long_after_flush", result, last_exp);

    // asynchronous reset between edges in the middle of RUN
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
    repeat (6) @(negedge clk);
    #3 rst_n = 1'b0; start = 1'b0;
    #1;
    chk("async_rst_stall", {31'h0, stall}, 32'h0);
    chk("async_rst_valid", {31'h0, result_valid}, 32'h0);
    chk("async_rst_result", result, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd5, 32'd9, 32'd3);

    for (int i = 0; i < 40; i++) do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
